// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock, LSB first.
// Operands are loaded on an accepted start. The result, the final borrow and
// the signed-overflow flag are registered and held until the next completion.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             diff_bit;
   logic             borrow_next;
   logic             last_bit;
   logic [WIDTH:0]   res_ext;
   logic [WIDTH-1:0] res_shift;

   // Full-subtractor cell on the current LSBs and the running borrow.
   assign diff_bit    = a_q[0] ^ b_q[0] ^ br_q;
   assign borrow_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

   // Difference bit enters from the MSB side; the concatenation keeps this
   // well-formed even when WIDTH is 1.
   assign res_ext   = {diff_bit, res_q};
   assign res_shift = res_ext[WIDTH:1];

   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   // Next-state and datapath update for the IDLE/SHIFT/DONE controller.
   always_comb begin
      // NOTE: every signal gets a hold value first so no path leaves it unassigned (no latches).
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      d_d     = d_q;
      br_d    = br_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               br_d    = bin;
               res_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = borrow_next;
            res_d = res_shift;
            cnt_d = cnt_q + CW'(1);
            if (last_bit) begin
               // On the last bit the operand LSBs are the original MSBs.
               d_d     = res_shift;
               bout_d  = borrow_next;
               ovf_d   = (a_q[0] != b_q[0]) && (res_shift[WIDTH-1] != a_q[0]);
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         d_q     <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         d_q     <= d_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign d    = d_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;
   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, ignored start,
// back-to-back operation, asynchronous reset, random and exhaustive WIDTH=1.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic [W-1:0] d;
   logic         bout;
   logic         ovf;
   logic         busy;
   logic         done;

   logic         start1;
   logic [0:0]   a1;
   logic [0:0]   b1;
   logic         bin1;
   logic [0:0]   d1;
   logic         bout1;
   logic         ovf1;
   logic         busy1;
   logic         done1;

   int vectors;
   int miscompares;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .bin  (bin),
      .d    (d),
      .bout (bout),
      .ovf  (ovf),
      .busy (busy),
      .done (done)
   );

   serial_subtractor #(.WIDTH(1)) dut1 (
      .clk  (clk),
      .rst  (rst),
      .start(start1),
      .a    (a1),
      .b    (b1),
      .bin  (bin1),
      .d    (d1),
      .bout (bout1),
      .ovf  (ovf1),
      .busy (busy1),
      .done (done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, signed overflow from the true range.
   function automatic void model(input int w, input int ua, input int ub, input int ubin,
                                 output int ed, output int eb, output int eo);
      int diff, half, sa, sb, sv;
      diff = (ua - ub - ubin) & ((1 << (w + 1)) - 1);
      ed   = diff & ((1 << w) - 1);
      eb   = (diff >> w) & 1;
      half = 1 << (w - 1);
      sa   = (ua >= half) ? ua - (1 << w) : ua;
      sb   = (ub >= half) ? ub - (1 << w) : ub;
      sv   = sa - sb - ubin;
      eo   = ((sv < -half) || (sv > half - 1)) ? 1 : 0;
   endfunction

   // One WIDTH=8 operation, starting at a negedge and ending at the negedge
   // of the done cycle. poke pulses start with new operands during SHIFT.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tbin, input bit poke);
      int ed, eb, eo;
      logic [W+1:0] prev;
      logic [W+1:0] got;
      logic [W+1:0] exp_v;
      model(W, int'(ta), int'(tb_v), int'(tbin), ed, eb, eo);
      exp_v = {eb[0], ed[W-1:0], eo[0]};
      prev  = {bout, d, ovf};
      a = ta; b = tb_v; bin = tbin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL accept: busy=%b done=%b, required busy=1 done=0", busy, done);
      end
      for (int k = 1; k <= W; k++) begin
         if (poke && k == 2) begin
            start = 1'b1; a = 8'hFF; b = 8'hFF;
         end
         if (poke && k == 3) start = 1'b0;
         @(negedge clk);
         vectors++;
         if (done !== (k == W) || busy !== (k < W)) begin
            miscompares++;
            $display("FAIL timing edge %0d: busy=%b done=%b, required busy=%b done=%b",
                     k, busy, done, (k < W), (k == W));
         end
         if (k < W) begin
            vectors++;
            if ({bout, d, ovf} !== prev) begin
               miscompares++;
               $display("FAIL hold edge %0d: {bout,d,ovf}=%h, required %h", k, {bout, d, ovf}, prev);
            end
         end
      end
      got = {bout, d, ovf};
      vectors++;
      if (got !== exp_v) begin
         miscompares++;
         $display("FAIL result a=%h b=%h bin=%b: bout=%b d=%h ovf=%b, required bout=%b d=%h ovf=%b",
                  ta, tb_v, tbin, got[W+1], got[W:1], got[0], exp_v[W+1], exp_v[W:1], exp_v[0]);
      end
   endtask

   task automatic check_cleared(input string tag);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || d !== '0 || bout !== 1'b0 || ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL %s: busy=%b done=%b d=%h bout=%b ovf=%b, required all zero",
                  tag, busy, done, d, bout, ovf);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
      repeat (2) @(negedge clk);
      check_cleared("reset_held");
      rst = 1'b0;
      @(negedge clk);
      check_cleared("reset_release");
   endtask

   task automatic test_directed();
      do_op(8'h05, 8'h03, 1'b0, 1'b0);
      start = 1'b0;
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL done_one_cycle: done=%b busy=%b, required 0 0", done, busy);
      end
      do_op(8'h03, 8'h05, 1'b0, 1'b0);
      do_op(8'h00, 8'h00, 1'b1, 1'b0);
      do_op(8'h80, 8'h01, 1'b0, 1'b0);
      do_op(8'h7F, 8'hFF, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_op(8'h10, 8'h01, 1'b0, 1'b1);
      do_op(8'h09, 8'h04, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      do_op(8'h7F, 8'hFF, 1'b0, 1'b0);
      a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_cleared("async_reset_immediate");
      @(negedge clk);
      check_cleared("async_reset_held");
      rst = 1'b0;
      @(negedge clk);
      check_cleared("async_reset_release");
      do_op(8'h33, 8'h11, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 1000; n++)
         do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_width1();
      int ed, eb, eo;
      for (int c = 0; c < 8; c++) begin
         a1 = 1'(c >> 2); b1 = 1'(c >> 1); bin1 = 1'(c);
         model(1, int'(a1), int'(b1), int'(bin1), ed, eb, eo);
         start1 = 1'b1;
         @(negedge clk);
         start1 = 1'b0;
         vectors++;
         if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            miscompares++;
            $display("FAIL w1_accept %0d: busy=%b done=%b, required 1 0", c, busy1, done1);
         end
         @(negedge clk);
         vectors++;
         if (done1 !== 1'b1 || busy1 !== 1'b0 || d1 !== ed[0:0] ||
             bout1 !== eb[0] || ovf1 !== eo[0]) begin
            miscompares++;
            $display("FAIL w1_result a=%b b=%b bin=%b: done=%b busy=%b d=%b bout=%b ovf=%b, required 1 0 %b %b %b",
                     a1, b1, bin1, done1, busy1, d1, bout1, ovf1, ed[0], eb[0], eo[0]);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_async_reset();
      test_random();
      test_width1();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
